// File: rtl/ms_stopwatch_pkg.sv
// Shared types and constants for the millisecond stopwatch.
// Imported by the digit slice and the top.
package ms_stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } sw_state_t;

  localparam int         DIG_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/ms_stopwatch_bcd_digit.sv
// One BCD digit of the cascaded stopwatch counter.
// carry fires on the tick that rolls this digit from 9 to 0.
import ms_stopwatch_pkg::*;

module bcd_digit (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [DIG_W-1:0] q,
  output logic             carry
);

  logic [DIG_W-1:0] q_q;

  assign q     = q_q;
  assign carry = inc && (q_q == BCD_MAX);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q_q <= '0;
    end else if (inc) begin
      q_q <= (q_q == BCD_MAX) ? '0 : q_q + 4'd1;
    end
  end

endmodule

// File: rtl/ms_stopwatch.sv
// Millisecond BCD stopwatch: run/stop FSM, lap freeze, sticky wrap flag.
// Digits are chained by carry; the last carry marks a wrap.
import ms_stopwatch_pkg::*;

module ms_stopwatch #(
  parameter int N_DIG = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   start_stop,
  input  logic                   clr,
  input  logic                   lap,
  output logic [DIG_W*N_DIG-1:0] cnt,
  output logic [DIG_W*N_DIG-1:0] disp,
  output logic                   run,
  output logic                   lap_hold,
  output logic                   ovf
);

  localparam int W = DIG_W * N_DIG;

  sw_state_t   state_q, state_d;
  logic [W-1:0] lap_q;
  logic         lap_hold_q, lap_hold_d;
  logic         lap_load;
  logic         run_q;
  logic         ovf_q;
  logic [N_DIG:0] inc_c;

  // Ticks count on the registered state, so a stop still counts its tick.
  assign inc_c[0] = ce && (state_q == RUN);

  for (genvar k = 0; k < N_DIG; k++) begin : g_dig
    bcd_digit u_dig (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .inc   (inc_c[k]),
      .q     (cnt[DIG_W*k +: DIG_W]),
      .carry (inc_c[k+1])
    );
  end

  always_comb begin
    state_d    = state_q;
    lap_hold_d = lap_hold_q;
    lap_load   = 1'b0;
    if (clr) begin
      state_d    = IDLE;
      lap_hold_d = 1'b0;
    end else begin
      if (start_stop) begin
        unique case (state_q)
          IDLE:    state_d = RUN;
          RUN:     state_d = STOP;
          STOP:    state_d = RUN;
          default: state_d = IDLE;
        endcase
      end
      if (lap) begin
        unique case (state_q)
          RUN: begin
            lap_hold_d = !lap_hold_q;
            lap_load   = !lap_hold_q;
          end
          STOP:    lap_hold_d = 1'b0;
          default: lap_hold_d = lap_hold_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lap_q      <= '0;
      lap_hold_q <= 1'b0;
      run_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lap_hold_q <= lap_hold_d;
      run_q      <= (state_d == RUN);
      if (clr) begin
        lap_q <= '0;
      end else if (lap_load) begin
        lap_q <= cnt;
      end
      if (clr) begin
        ovf_q <= 1'b0;
      end else if (inc_c[N_DIG]) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign run      = run_q;
  assign lap_hold = lap_hold_q;
  assign ovf      = ovf_q;
  assign disp     = lap_hold_q ? lap_q : cnt;

endmodule

// File: tb/tb_ms_stopwatch.sv
// Directed bench for ms_stopwatch.
// Inputs change at negedge; outputs are checked at the following negedge.
module tb_ms_stopwatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce, start_stop, clr, lap;
  logic [15:0] cnt, disp;
  logic        run, lap_hold, ovf;

  int n_tests = 0;
  int n_fail  = 0;

  ms_stopwatch #(.N_DIG(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .start_stop (start_stop),
    .clr        (clr),
    .lap        (lap),
    .cnt        (cnt),
    .disp       (disp),
    .run        (run),
    .lap_hold   (lap_hold),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic c, input logic s,
                      input logic k, input logic l);
    ce         = c;
    start_stop = s;
    clr        = k;
    lap        = l;
    @(negedge clk);
    ce         = 1'b0;
    start_stop = 1'b0;
    clr        = 1'b0;
    lap        = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_all(input string tag, input logic [15:0] c,
                         input logic [15:0] d, input logic r,
                         input logic h, input logic o);
    chk({tag, ".cnt"},  32'(cnt),      32'(c));
    chk({tag, ".disp"}, 32'(disp),     32'(d));
    chk({tag, ".run"},  32'(run),      32'(r));
    chk({tag, ".lap"},  32'(lap_hold), 32'(h));
    chk({tag, ".ovf"},  32'(ovf),      32'(o));
  endtask

  initial begin
    rst = 1'b1;
    ce = 1'b0; start_stop = 1'b0; clr = 1'b0; lap = 1'b0;
    @(negedge clk);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    chk_all("reset", 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

    ticks(3);
    chk("idle_ce", 32'(cnt), 32'h0);

    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk_all("start", 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    ticks(1234);
    chk_all("c1234", 16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0);

    ticks(8765);
    chk_all("c9999", 16'h9999, 16'h9999, 1'b1, 1'b0, 1'b0);
    ticks(1);
    chk_all("wrap", 16'h0, 16'h0, 1'b1, 1'b0, 1'b1);
    ticks(5);
    chk_all("wrap5", 16'h0005, 16'h0005, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk_all("clr", 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    ticks(2);
    chk("clr_idle", 32'(cnt), 32'h0);

    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(250);
    chk("c0250", 32'(cnt), 32'h0250);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_all("lap_on", 16'h0250, 16'h0250, 1'b1, 1'b1, 1'b0);
    ticks(50);
    chk_all("lap_frz", 16'h0300, 16'h0250, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_all("lap_off", 16'h0300, 16'h0300, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk_all("lap_pre", 16'h0301, 16'h0300, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk_all("stop_h", 16'h0301, 16'h0300, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_all("stop_lap", 16'h0301, 16'h0301, 1'b0, 1'b0, 1'b0);

    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(99);
    chk("c0099", 32'(cnt), 32'h0099);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk_all("stop_ce", 16'h0100, 16'h0100, 1'b0, 1'b0, 1'b0);
    ticks(7);
    chk("stop_hold", 32'(cnt), 32'h0100);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk_all("resume", 16'h0100, 16'h0100, 1'b1, 1'b0, 1'b0);
    ticks(1);
    chk("resume_t", 32'(cnt), 32'h0101);

    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("lap_set", 32'(lap_hold), 32'h1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk_all("clr_all", 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    ticks(2);
    chk("clr_all_i", 32'(cnt), 32'h0);

    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(777);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_all("pre_rst", 16'h0777, 16'h0777, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk_all("mid_rst", 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    ticks(4);
    chk("rst_idle", 32'(cnt), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1);
    chk_all("rst_run", 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
